add_seq: RTL and testbench
==========================

# add_seq

Multi-cycle adder controller. It sequences one shared 8-bit ripple-carry adder slice across a wide operand, one byte per cycle, with a registered carry between slices. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. This lets wide additions (default 32-bit) be built from a single 8-bit full-adder datapath.

## Interface
- WORDS, default 4: number of 8-bit slices; operand width W = 8*WORDS; legal range 1..16.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept operands (high only in IDLE).
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  0 = A+B, 1 = A-B (present only when ADD_SEQ_SUB_EN is defined).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- cout  out  1  carry out of MSB (for subtraction: 1 = no borrow).
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=1. On in_valid:
  - capture a, b (b inverted when sub=1) and op;
  - carry reg = sub (0 without the macro);
  - idx = 0;
  - go to RUN.
- RUN: each cycle:
  - apply slice idx of A, B and the carry reg to the adder;
  - write the sum into result[8*idx +: 8];
  - carry reg = slice carry out;
  - idx++.
- Leaving RUN: when idx == WORDS-1, latch cout from the final slice carry, latch ovf from the slice MSB carry-in XOR carry-out, then go to HOLD.
- HOLD: out_valid=1. result, cout and ovf stay stable until out_ready. On out_ready go to IDLE.
- Input behaviour:
  - in_valid outside IDLE is ignored (in_ready=0); no buffering.
  - a and b may change after acceptance; internal copies are used.
- Arithmetic: modulo 2^W. Unsigned overflow is reported by cout, signed overflow by ovf.
- Async reset (including mid-RUN or in HOLD) aborts the operation. No partial result is ever presented.

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, result=0, cout=0, ovf=0, idx=0, carry reg=0.
- Accept edge = cycle 0. RUN occupies cycles 1..WORDS. out_valid rises at edge WORDS+1 after acceptance (WORDS=4: 5 edges).
- out_valid and out_ready high at the same edge → return to IDLE. in_ready rises the following cycle, so there is no same-cycle back-to-back accept.
- Minimum throughput: one operation per WORDS+2 cycles.
- WORDS=1: RUN lasts a single cycle; the same rules apply.
- result bytes update progressively during RUN. Consumers must only sample result when out_valid=1.
- in_ready and out_valid are never both high.

## Configuration
- ADD_SEQ_SUB_EN defined:
  - sub port exists;
  - B is inverted on capture and the initial carry is 1 when sub=1;
  - cout=1 means A >= B (unsigned).
- Not defined:
  - no sub port;
  - addition only, with the initial carry fixed at 0;
  - no B inversion logic.

## Structure
- Shared package add_seq_pkg:
  - state enum (IDLE, RUN, HOLD);
  - SLICE_W = 8;
  - idx width function clog2(WORDS) (minimum 1).
- Sub-module add_slice8: purely combinational 8-bit ripple-carry adder, built as a chain of full-adder cells (S = a^b^c, cout = ab | c(a^b)).
  - Outputs: sum[7:0], carry out, and carry into bit 7 (for ovf).
  - add_seq instantiates exactly one add_slice8.

## Test plan
- WORDS=4, A=0x0000000B, B=0x00000004 → result=0x0000000F, cout=0, ovf=0; out_valid exactly 5 edges after accept.
- A=0xFFFFFFFF, B=0x00000001 → result=0x00000000, cout=1, ovf=0 (carry ripples through all 4 slices).
- A=0x7FFFFFFF, B=0x00000001 → result=0x80000000, cout=0, ovf=1.
- ADD_SEQ_SUB_EN defined:
  - sub=1, A=5, B=7 → result=0xFFFFFFFE, cout=0, ovf=0;
  - A=7, B=5 → result=0x00000002, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in HOLD → result, cout and ovf are stable, in_ready=0, and a new in_valid is ignored. Then assert out_ready → IDLE, and in_ready=1 the next cycle.
- Assert rst_n=0 in cycle 2 of RUN → out_valid=0 and result=0 immediately, state IDLE. After release, a fresh 1+1 yields 0x00000002.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multi-cycle byte-serial adder.
package add_seq_pkg;

    // Controller phases: waiting for operands, stepping slices, presenting result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int SLICE_W = 8;

    // Bits needed to index WORDS slices; never narrower than one bit.
    function automatic int idx_w(input int words);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++)
            if ((1 << r) < words) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_seq_slice.sv
// add_slice8: combinational 8-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module add_slice8
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c7
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit, carries chained LSB to MSB.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];
    assign c7   = c[SLICE_W-1];

endmodule

// File: rtl/add_seq.sv
// add_seq: sequences one shared 8-bit adder slice over a WORDS*8-bit operand,
// one byte per cycle, with a registered carry between slices.
// Optional subtraction (sub port, B inverted, carry-in 1) under ADD_SEQ_SUB_EN.
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
`ifdef ADD_SEQ_SUB_EN
    input  logic                     sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] result,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W  = SLICE_W * WORDS;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t              state, state_nx;
    logic [W-1:0]        a_q, b_q;
    logic                carry_q;
    logic [IW-1:0]       idx;

    logic [SLICE_W-1:0]  sl_a, sl_b, sl_sum;
    logic                sl_cout, sl_c7;

    // Handshake flags come straight from the state so they can never overlap.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    // Present the current byte of the captured operands to the shared slice.
    assign sl_a = a_q[int'(idx)*SLICE_W +: SLICE_W];
    assign sl_b = b_q[int'(idx)*SLICE_W +: SLICE_W];

    add_slice8 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout),
        .c7   (sl_c7)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: accept in IDLE, step until the last slice, hold until consumed.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)     state_nx = RUN;
            RUN:     if (idx == LAST)  state_nx = HOLD;
            HOLD:    if (out_ready)    state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then write one result byte per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
`ifdef ADD_SEQ_SUB_EN
                        // A - B computed as A + ~B + 1.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
`else
                        b_q     <= b;
                        carry_q <= 1'b0;
`endif
                        idx <= '0;
                    end
                end
                RUN: begin
                    result[int'(idx)*SLICE_W +: SLICE_W] <= sl_sum;
                    carry_q <= sl_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout <= sl_cout;
                        ovf  <= sl_c7 ^ sl_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: directed operand pairs with hand-computed results, plus a
// spec-level model (plain wide arithmetic and an edge counter) compared every cycle.
module tb_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout, ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts edges since acceptance, the accept edge being edge 1;
    // -1 means no operation in flight. Result is visible once WORDS+1 edges seen.
    int           m_age = -1;
    logic [W-1:0] m_res;
    logic         m_cout, m_ovf;
    logic [W-1:0] t_b;
    logic [W:0]   t_s;
    logic         t_sub;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age <= -1;
        end else if (m_age == -1) begin
            if (in_valid) begin
`ifdef ADD_SEQ_SUB_EN
                t_sub = sub;
`else
                t_sub = 1'b0;
`endif
                t_b = t_sub ? ~b : b;
                t_s = {1'b0, a} + {1'b0, t_b} + {{W{1'b0}}, t_sub};
                m_res  <= t_s[W-1:0];
                m_cout <= t_s[W];
                m_ovf  <= (a[W-1] == t_b[W-1]) && (t_s[W-1] != a[W-1]);
                m_age  <= 1;
            end
        end else if (m_age <= WORDS) begin
            m_age <= m_age + 1;
        end else if (out_ready) begin
            m_age <= -1;
        end
    end

    // Per-cycle comparison of handshakes and, while valid, the result fields.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_model",  {{(W-1){1'b0}}, in_ready},  {{(W-1){1'b0}}, (m_age == -1)});
            check("out_valid_model", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, (m_age == WORDS + 1)});
            check("ready_valid_excl", {{(W-1){1'b0}}, in_ready & out_valid}, '0);
            if (m_age == WORDS + 1) begin
                check("result_model", result, m_res);
                check("cout_model", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, m_cout});
                check("ovf_model",  {{(W-1){1'b0}}, ovf},  {{(W-1){1'b0}}, m_ovf});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic ts, input logic [W-1:0] er, input logic ec,
                          input logic eo, input int hold);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        check({nm, "_ready_timeout"}, {{(W-1){1'b0}}, in_ready}, 1);
        a = ta; b = tb_; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands may change once accepted.
        a = $urandom; b = $urandom;
        t = 1;
        while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
        check({nm, "_latency"}, t, WORDS + 1);
        check({nm, "_result"}, result, er);
        check({nm, "_cout"}, {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, ec});
        check({nm, "_ovf"},  {{(W-1){1'b0}}, ovf},  {{(W-1){1'b0}}, eo});
        // Backpressure: new offers must be ignored while the result waits.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check({nm, "_hold_result"}, result, er);
            check({nm, "_hold_valid"}, {{(W-1){1'b0}}, out_valid}, 1);
            check({nm, "_hold_cout"}, {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, ec});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_back_idle"}, {{(W-1){1'b0}}, in_ready}, 1);
        check({nm, "_valid_drop"}, {{(W-1){1'b0}}, out_valid}, 0);
    endtask

    initial begin
        // Reset state.
        #23;
        check("rst_result", result, '0);
        check("rst_cout", {{(W-1){1'b0}}, cout}, '0);
        check("rst_ovf",  {{(W-1){1'b0}}, ovf},  '0);
        check("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("rst_in_ready",  {{(W-1){1'b0}}, in_ready}, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_small", 32'h0000000B, 32'h00000004, 1'b0, 32'h0000000F, 1'b0, 1'b0, 0);
        run_op("add_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
        run_op("add_sovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 3);
        run_op("add_negovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1);
        run_op("add_mixed", 32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0, 0);
`ifdef ADD_SEQ_SUB_EN
        run_op("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        run_op("sub_pos", 32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 2);
`endif

        // Abort during the second RUN cycle; partial bytes must vanish.
        a = 32'h11223344; b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("abort_result", result, '0);
        check("abort_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
